clock_period_meter: RTL and testbench

- Measures the divided clock produced by the team's clock divider, i.e. any slow, asynchronous square wave on sig_in, by counting clk cycles.
- Reports the period and the high time of sig_in, with a one-cycle valid strobe, a lock indication and a timeout indication.
- Sits in the clk (50 MHz) domain and consumes the slow clock as data, never as a clock.
- Used on-board to check divider settings and by logic that needs the measured rate.

---
 rtl/clock_meter_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/clock_period_meter.sv | 142 ++++++++++++++
 tb/tb_clock_period_meter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_meter_pkg;

    // Measurement state: waiting for a first rising edge, or timing periods.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_TIMEOUT     = 200_000_000;
    localparam int DEF_MIN_PERIOD  = 4;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a delay
// flop that yields single-cycle rise and fall strobes. SYNC_STAGES >= 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchroniser, then remember the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles. The signal is only ever sampled as data. cnt holds the number of
// clk edges since the last detected rise (1 on the edge after the rise), so
// at the next rise it equals the period directly; at a fall it equals the
// high time directly.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic             glitch
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic sig_level;
    logic sig_rise;
    logic sig_fall;

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             glitch_q, glitch_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .level (sig_level),
        .rise  (sig_rise),
        .fall  (sig_fall)
    );

    // Cycle counter: restarts on every rise, saturates at TIMEOUT so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (sig_rise) begin
            cnt_d = ONE_C;
        end else if (cnt_q >= TIMEOUT_C) begin
            cnt_d = TIMEOUT_C;
        end else begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    // Next-state and output logic; a rise always wins over the timeout check.
    always_comb begin
        state_d   = state_q;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        glitch_d  = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (sig_rise) begin
                    state_d  = MEASURE;
                    hi_cap_d = '0;
                end
            end
            MEASURE: begin
                if (sig_rise) begin
                    hi_cap_d = '0;
                    if (cnt_q >= MIN_C) begin
                        period_d  = cnt_q;
                        // Input stayed high the whole period: high time equals the period.
                        high_d    = (hi_cap_q == '0) ? cnt_q : hi_cap_q;
                        valid_d   = 1'b1;
                        locked_d  = 1'b1;
                        timeout_d = 1'b0;
                    end else begin
                        glitch_d = 1'b1;
                    end
                end else if (sig_fall) begin
                    hi_cap_d = cnt_q;
                end else if (cnt_q >= TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            glitch_q  <= glitch_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign glitch       = glitch_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with TIMEOUT=50, MIN_PERIOD=4.
module tb_clock_period_meter;

    localparam int CNT_W = 32;
    localparam int TO    = 50;
    localparam int MINP  = 4;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    logic             glitch;

    int total = 0;
    int bad   = 0;

    // Monitor state, written only by the negedge monitor.
    logic [CNT_W-1:0] p_log[$];
    logic [CNT_W-1:0] h_log[$];
    int   cyc         = 0;
    int   last_pv_cyc = 0;
    int   to_rise_cyc = 0;
    int   glitch_cnt  = 0;
    int   pv_double   = 0;
    int   gl_double   = 0;
    logic pv_prev     = 1'b0;
    logic gl_prev     = 1'b0;
    logic to_prev     = 1'b0;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TO),
        .MIN_PERIOD (MINP),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout),
        .glitch      (glitch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (period_valid === 1'b1) begin
            p_log.push_back(period);
            h_log.push_back(high_time);
            last_pv_cyc = cyc;
            if (pv_prev === 1'b1) pv_double = pv_double + 1;
            $display("txn cyc=%0d period_valid period=%0d high_time=%0d locked=%0b", cyc, period, high_time, locked);
        end
        if (glitch === 1'b1) begin
            glitch_cnt = glitch_cnt + 1;
            if (gl_prev === 1'b1) gl_double = gl_double + 1;
            $display("txn cyc=%0d glitch", cyc);
        end
        if (timeout === 1'b1 && to_prev !== 1'b1) begin
            to_rise_cyc = cyc;
            $display("txn cyc=%0d timeout set", cyc);
        end
        pv_prev = period_valid;
        gl_prev = glitch;
        to_prev = timeout;
    end

    task automatic set_sig(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            set_sig(1'b1, hi);
            set_sig(1'b0, lo);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        total++; if (period !== '0) begin bad++; $display("FAIL %s period: got %0d expected 0", tag, period); end
        total++; if (high_time !== '0) begin bad++; $display("FAIL %s high_time: got %0d expected 0", tag, high_time); end
        total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL %s period_valid: got %b expected 0", tag, period_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL %s locked: got %b expected 0", tag, locked); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL %s timeout: got %b expected 0", tag, timeout); end
        total++; if (glitch !== 1'b0) begin bad++; $display("FAIL %s glitch: got %b expected 0", tag, glitch); end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Toggle every 5 clk: first rise only arms, later rises report 10/5.
    task automatic test_basic();
        int n0;
        n0 = p_log.size();
        wave(5, 5, 1);
        total++; if (p_log.size() - n0 !== 0) begin bad++; $display("FAIL basic_first_rise pv count: got %0d expected 0", p_log.size() - n0); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL basic_first_rise locked: got %b expected 0", locked); end
        wave(5, 5, 4);
        total++; if (p_log.size() - n0 !== 4) begin bad++; $display("FAIL basic pv count: got %0d expected 4", p_log.size() - n0); end
        for (int i = n0; i < p_log.size(); i++) begin
            total++; if (p_log[i] !== 32'd10) begin bad++; $display("FAIL basic period[%0d]: got %0d expected 10", i, p_log[i]); end
            total++; if (h_log[i] !== 32'd5) begin bad++; $display("FAIL basic high_time[%0d]: got %0d expected 5", i, h_log[i]); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL basic locked: got %b expected 1", locked); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL basic timeout: got %b expected 0", timeout); end
    endtask

    // Duty-cycle 3/7, then rate change to 6/6.
    task automatic test_duty();
        int n0;
        n0 = p_log.size();
        wave(3, 7, 3);
        total++; if (p_log.size() - n0 !== 3) begin bad++; $display("FAIL duty37 pv count: got %0d expected 3", p_log.size() - n0); end
        total++; if (period !== 32'd10) begin bad++; $display("FAIL duty37 period: got %0d expected 10", period); end
        total++; if (high_time !== 32'd3) begin bad++; $display("FAIL duty37 high_time: got %0d expected 3", high_time); end
        wave(6, 6, 2);
        total++; if (p_log.size() - n0 !== 5) begin bad++; $display("FAIL duty66 pv count: got %0d expected 5", p_log.size() - n0); end
        total++; if (p_log[n0+3] !== 32'd10 || h_log[n0+3] !== 32'd3) begin bad++; $display("FAIL duty_transition: got %0d/%0d expected 10/3", p_log[n0+3], h_log[n0+3]); end
        total++; if (period !== 32'd12) begin bad++; $display("FAIL duty66 period: got %0d expected 12", period); end
        total++; if (high_time !== 32'd6) begin bad++; $display("FAIL duty66 high_time: got %0d expected 6", high_time); end
    endtask

    // Lock at 10, stop toggling, expect timeout exactly 50 cycles after the last rise.
    task automatic test_timeout();
        int n1;
        wave(5, 5, 3);
        total++; if (period !== 32'd10) begin bad++; $display("FAIL to_prelock period: got %0d expected 10", period); end
        sig_in = 1'b0;
        for (int i = 0; i < 200 && timeout !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_timeout: got %b expected 1", timeout); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_locked: got %b expected 0", locked); end
        total++; if (period !== 32'd10) begin bad++; $display("FAIL to_period_hold: got %0d expected 10", period); end
        total++; if (high_time !== 32'd5) begin bad++; $display("FAIL to_high_hold: got %0d expected 5", high_time); end
        total++; if (to_rise_cyc - last_pv_cyc !== TO) begin bad++; $display("FAIL to_latency: got %0d expected %0d", to_rise_cyc - last_pv_cyc, TO); end
        n1 = p_log.size();
        wave(5, 5, 1);
        total++; if (p_log.size() - n1 !== 0) begin bad++; $display("FAIL to_resume1 pv count: got %0d expected 0", p_log.size() - n1); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_resume1 timeout: got %b expected 1", timeout); end
        wave(5, 5, 1);
        total++; if (p_log.size() - n1 !== 1) begin bad++; $display("FAIL to_resume2 pv count: got %0d expected 1", p_log.size() - n1); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_resume2 timeout: got %b expected 0", timeout); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_resume2 locked: got %b expected 1", locked); end
        total++; if (period !== 32'd10) begin bad++; $display("FAIL to_resume2 period: got %0d expected 10", period); end
    endtask

    // Rise, 1-clk dip, glitch rise 2 cycles after the rise, next rise 10 cycles after
    // the first: period 8 counted from the glitch edge, high 3.
    task automatic test_glitch();
        int n0;
        int g0;
        n0 = p_log.size();
        g0 = glitch_cnt;
        set_sig(1'b1, 1);
        set_sig(1'b0, 1);
        set_sig(1'b1, 3);
        set_sig(1'b0, 5);
        set_sig(1'b1, 5);
        set_sig(1'b0, 5);
        total++; if (glitch_cnt - g0 !== 1) begin bad++; $display("FAIL glitch count: got %0d expected 1", glitch_cnt - g0); end
        total++; if (gl_double !== 0) begin bad++; $display("FAIL glitch width: got %0d long pulses expected 0", gl_double); end
        total++; if (p_log.size() - n0 !== 2) begin bad++; $display("FAIL glitch pv count: got %0d expected 2", p_log.size() - n0); end
        total++; if (p_log[n0] !== 32'd10) begin bad++; $display("FAIL glitch pre period: got %0d expected 10", p_log[n0]); end
        total++; if (period !== 32'd8) begin bad++; $display("FAIL glitch period: got %0d expected 8", period); end
        total++; if (high_time !== 32'd3) begin bad++; $display("FAIL glitch high_time: got %0d expected 3", high_time); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL glitch locked: got %b expected 1", locked); end
    endtask

    // Asynchronous reset between clk edges, mid-period.
    task automatic test_async_reset();
        int n0;
        set_sig(1'b1, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = p_log.size();
        wave(5, 5, 1);
        total++; if (p_log.size() - n0 !== 0) begin bad++; $display("FAIL rst_first_rise pv count: got %0d expected 0", p_log.size() - n0); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_first_rise locked: got %b expected 0", locked); end
        wave(5, 5, 1);
        total++; if (p_log.size() - n0 !== 1) begin bad++; $display("FAIL rst_second_rise pv count: got %0d expected 1", p_log.size() - n0); end
        total++; if (period !== 32'd10) begin bad++; $display("FAIL rst_period: got %0d expected 10", period); end
        total++; if (high_time !== 32'd5) begin bad++; $display("FAIL rst_high_time: got %0d expected 5", high_time); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL rst_locked: got %b expected 1", locked); end
    endtask

    // Input edges at several fixed phases between clk edges, period 10.
    task automatic test_phase();
        int phases[4] = '{1, 3, 6, 9};
        int n0;
        for (int p = 0; p < 4; p++) begin
            @(posedge clk);
            #(phases[p]);
            repeat (2) begin
                sig_in = 1'b1; #50;
                sig_in = 1'b0; #50;
            end
            n0 = p_log.size();
            repeat (4) begin
                sig_in = 1'b1; #50;
                sig_in = 1'b0; #50;
            end
            total++; if (p_log.size() - n0 !== 4) begin bad++; $display("FAIL phase%0d pv count: got %0d expected 4", phases[p], p_log.size() - n0); end
            for (int i = n0; i < p_log.size(); i++) begin
                total++; if (p_log[i] !== 32'd10) begin bad++; $display("FAIL phase%0d period[%0d]: got %0d expected 10", phases[p], i, p_log[i]); end
                total++; if (h_log[i] !== 32'd5) begin bad++; $display("FAIL phase%0d high_time[%0d]: got %0d expected 5", phases[p], i, h_log[i]); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty();
        test_timeout();
        test_glitch();
        test_async_reset();
        test_phase();
        total++; if (pv_double !== 0) begin bad++; $display("FAIL pv_width: got %0d long pulses expected 0", pv_double); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
